// File: rtl/ip_fetch_queue_pkg.sv
// ip_fetch_queue_pkg
// Shared types and helpers for the two-wide instruction fetch queue.
//   FETCH_WIDTH   : instructions per fetch group / per loader cycle
//   INSTR_WIDTH   : default address and instruction width
//   fetch_entry_t : one queue entry {address, instruction}
//   pops_from_take: loader take mask -> requested pop count (2'b10 pops nothing)
//   min2          : smaller of two 2-bit counts
package ip_fetch_queue_pkg;

  localparam int FETCH_WIDTH = 2;
  localparam int INSTR_WIDTH = 32;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] address;
    logic [INSTR_WIDTH-1:0] instruction;
  } fetch_entry_t;

  function automatic logic [1:0] pops_from_take(input logic [1:0] take);
    logic [1:0] n;
    case (take)
      2'b11:   n = 2'd2;
      2'b01:   n = 2'd1;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ip_fetch_queue_ram.sv
// ip_fetch_queue_ram
// DEPTH-entry storage for the fetch queue. Two write ports (group entry 0
// and 1) and two combinational read ports (slot 0 and 1). No reset: the
// pointers in the parent decide which entries are meaningful.
//   clock              : rising-edge clock
//   we0_i/waddr0_i/wdata0_i, we1_i/waddr1_i/wdata1_i : write ports
//   raddr0_i/rdata0_o, raddr1_i/rdata1_o             : read ports
module ip_fetch_queue_ram
  import ip_fetch_queue_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clock,
  input  logic                     we0_i,
  input  logic [$clog2(DEPTH)-1:0] waddr0_i,
  input  entry_t                   wdata0_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] waddr1_i,
  input  entry_t                   wdata1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr0_i,
  output entry_t                   rdata0_o,
  input  logic [$clog2(DEPTH)-1:0] raddr1_i,
  output entry_t                   rdata1_o
);

  entry_t mem_q [DEPTH];

  // Entry storage write; the two write addresses are always distinct.
  always_ff @(posedge clock) begin
    if (we0_i) begin
      mem_q[waddr0_i] <= wdata0_i;
    end
    if (we1_i) begin
      mem_q[waddr1_i] <= wdata1_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/ip_fetch_queue.sv
// ip_fetch_queue
// Two-wide circular instruction fetch queue between the I-cache and the
// loader. Accepts up to two sequential instructions per cycle, presents the
// two oldest entries with their addresses, and drops everything on flush.
// Optional feature macro: IP_FETCH_QUEUE_BYPASS_EN (same-cycle pass-through
// of an incoming group when the queue is empty).
// Ports:
//   clock, reset (async, active-high), flush
//   in_valid/in_ready/in_address/in_data/in_count : fetch-side group
//   out_valid/out_instr_0/1/out_address_0/1/out_take : loader-side slots
//   count : current occupancy
module ip_fetch_queue
  import ip_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_address,
  input  logic [2*XLEN-1:0]      in_data,
  input  logic [1:0]             in_count,
  output logic [1:0]             out_valid,
  output logic [XLEN-1:0]        out_instr_0,
  output logic [XLEN-1:0]        out_instr_1,
  output logic [XLEN-1:0]        out_address_0,
  output logic [XLEN-1:0]        out_address_1,
  input  logic [1:0]             out_take,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] instruction;
  } entry_t;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_s;
  logic [1:0]    push_n_s, req_pop_s, avail_s, pop_n_s, skip_s, write_n_s;
  logic          push_ok_s, bypass_s;
  logic          we0_s, we1_s;
  entry_t        grp0_s, grp1_s, wdata0_s, rdata0_s, rdata1_s;
  logic [FETCH_WIDTH-1:0] slot_valid_s;

  // Occupancy falls out of the wrap-bit pointers, so full and empty never alias.
  assign count_s  = wr_ptr_q - rd_ptr_q;
  assign count    = count_s;
  assign in_ready = (count_s <= PW'(DEPTH - 2));

  assign grp0_s.address     = in_address;
  assign grp0_s.instruction = in_data[XLEN-1:0];
  assign grp1_s.address     = in_address + XLEN'(4);
  assign grp1_s.instruction = in_data[2*XLEN-1:XLEN];

  assign push_n_s  = in_count[1] ? 2'd2 : in_count;
  assign push_ok_s = in_valid & in_ready & ~flush & ~reset & (push_n_s != 2'd0);
  assign req_pop_s = pops_from_take(out_take);

`ifdef IP_FETCH_QUEUE_BYPASS_EN
  assign bypass_s = push_ok_s & (count_s == {PW{1'b0}});
`else
  assign bypass_s = 1'b0;
`endif

  // Slots available to the loader this cycle, the actual pop count, and how
  // many incoming entries are consumed by bypass instead of being written.
  always_comb begin
    avail_s   = 2'd0;
    pop_n_s   = 2'd0;
    skip_s    = 2'd0;
    write_n_s = 2'd0;
    if (bypass_s) begin
      avail_s = push_n_s;
    end else if (count_s >= PW'(2)) begin
      avail_s = 2'd2;
    end else begin
      avail_s = count_s[1:0];
    end
    pop_n_s = min2(req_pop_s, avail_s);
    if (bypass_s) begin
      skip_s = pop_n_s;
    end else begin
      skip_s = 2'd0;
    end
    if (push_ok_s) begin
      write_n_s = push_n_s - skip_s;
    end else begin
      write_n_s = 2'd0;
    end
  end

  // The first entry written is group entry 1 when bypass already took entry 0.
  assign we0_s    = (write_n_s != 2'd0);
  assign we1_s    = (write_n_s == 2'd2);
  assign wdata0_s = (skip_s == 2'd0) ? grp0_s : grp1_s;

  // Pointer next state; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
    end else if (bypass_s) begin
      wr_ptr_d = wr_ptr_q + PW'(write_n_s);
      rd_ptr_d = rd_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(write_n_s);
      rd_ptr_d = rd_ptr_q + PW'(pop_n_s);
    end
  end

  // Pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  ip_fetch_queue_ram #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ram (
    .clock    (clock),
    .we0_i    (we0_s),
    .waddr0_i (wr_ptr_q[IW-1:0]),
    .wdata0_i (wdata0_s),
    .we1_i    (we1_s),
    .waddr1_i (wr_ptr_q[IW-1:0] + IW'(1)),
    .wdata1_i (grp1_s),
    .raddr0_i (rd_ptr_q[IW-1:0]),
    .rdata0_o (rdata0_s),
    .raddr1_i (rd_ptr_q[IW-1:0] + IW'(1)),
    .rdata1_o (rdata1_s)
  );

  // Output slots: bypassed group when empty, otherwise the two oldest entries;
  // invalid slots are forced to zero.
  always_comb begin
    slot_valid_s  = {FETCH_WIDTH{1'b0}};
    out_instr_0   = {XLEN{1'b0}};
    out_instr_1   = {XLEN{1'b0}};
    out_address_0 = {XLEN{1'b0}};
    out_address_1 = {XLEN{1'b0}};
    if (bypass_s) begin
      slot_valid_s[0] = 1'b1;
      slot_valid_s[1] = (push_n_s == 2'd2);
      out_instr_0     = grp0_s.instruction;
      out_address_0   = grp0_s.address;
      if (push_n_s == 2'd2) begin
        out_instr_1   = grp1_s.instruction;
        out_address_1 = grp1_s.address;
      end else begin
        out_instr_1   = {XLEN{1'b0}};
        out_address_1 = {XLEN{1'b0}};
      end
    end else begin
      slot_valid_s[0] = (count_s >= PW'(1));
      slot_valid_s[1] = (count_s >= PW'(2));
      if (slot_valid_s[0]) begin
        out_instr_0   = rdata0_s.instruction;
        out_address_0 = rdata0_s.address;
      end else begin
        out_instr_0   = {XLEN{1'b0}};
        out_address_0 = {XLEN{1'b0}};
      end
      if (slot_valid_s[1]) begin
        out_instr_1   = rdata1_s.instruction;
        out_address_1 = rdata1_s.address;
      end else begin
        out_instr_1   = {XLEN{1'b0}};
        out_address_1 = {XLEN{1'b0}};
      end
    end
  end

  assign out_valid = slot_valid_s;

endmodule

// File: tb/tb_ip_fetch_queue.sv
// tb_ip_fetch_queue
// Self-checking bench: a queue-of-entries model predicts every output each
// cycle; literal expectations at key points pin the model itself.
// Honours IP_FETCH_QUEUE_BYPASS_EN when the build defines it.
module tb_ip_fetch_queue;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_address = 32'd0;
  logic [63:0] in_data = 64'd0;
  logic [1:0]  in_count = 2'd0;
  logic [1:0]  out_valid;
  logic [31:0] out_instr_0, out_instr_1, out_address_0, out_address_1;
  logic [1:0]  out_take = 2'd0;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: oldest entry first, each entry {address, instruction}
  logic [63:0] mq[$];
  logic        m_acc, m_byp;
  int          m_pn, m_tn;
  logic [63:0] m_g0, m_g1;

  always #5 clock = ~clock;

  ip_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_address(in_address),
    .in_data(in_data), .in_count(in_count),
    .out_valid(out_valid), .out_instr_0(out_instr_0), .out_instr_1(out_instr_1),
    .out_address_0(out_address_0), .out_address_1(out_address_1),
    .out_take(out_take), .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs just after a falling edge, then compare against the model.
  task automatic drive(input logic v, input logic [31:0] a, input logic [63:0] d,
                       input logic [1:0] c, input logic [1:0] t, input logic f);
    int cnt, vs;
    logic [63:0] v0, v1;
    in_valid = v; in_address = a; in_data = d; in_count = c; out_take = t; flush = f;
    #1;
    if (reset) mq.delete();
    cnt   = mq.size();
    m_pn  = int'(c);
    m_tn  = (t == 2'b11) ? 2 : (t[0] ? 1 : 0);
    m_acc = v && (cnt <= DEPTH - 2) && !f && (c != 2'd0) && !reset;
    m_g0  = {a, d[31:0]};
    m_g1  = {a + 32'd4, d[63:32]};
    m_byp = 1'b0;
`ifdef IP_FETCH_QUEUE_BYPASS_EN
    m_byp = m_acc && (cnt == 0);
`endif
    if (m_byp) begin
      vs = m_pn; v0 = m_g0; v1 = m_g1;
    end else begin
      vs = cnt;
      v0 = (cnt > 0) ? mq[0] : 64'd0;
      v1 = (cnt > 1) ? mq[1] : 64'd0;
    end
    if (vs < 2) v1 = 64'd0;
    if (vs < 1) v0 = 64'd0;
    chk("out_valid", 64'(out_valid), (vs >= 2) ? 64'd3 : 64'(vs));
    chk("out_address_0", 64'(out_address_0), 64'(v0[63:32]));
    chk("out_instr_0", 64'(out_instr_0), 64'(v0[31:0]));
    chk("out_address_1", 64'(out_address_1), 64'(v1[63:32]));
    chk("out_instr_1", 64'(out_instr_1), 64'(v1[31:0]));
    chk("count", 64'(count), 64'(cnt));
    chk("in_ready", 64'(in_ready), (cnt <= DEPTH - 2) ? 64'd1 : 64'd0);
  endtask

  // Advance one clock and apply the queue rules to the model.
  task automatic tick();
    int k, cnt;
    @(posedge clock);
    cnt = mq.size();
    if (reset || flush) begin
      mq.delete();
    end else if (m_byp) begin
      k = (m_tn < m_pn) ? m_tn : m_pn;
      if (k == 0) mq.push_back(m_g0);
      if (m_pn == 2 && k < 2) mq.push_back(m_g1);
    end else begin
      k = (m_tn < cnt) ? m_tn : cnt;
      repeat (k) void'(mq.pop_front());
      if (m_acc) begin
        mq.push_back(m_g0);
        if (m_pn == 2) mq.push_back(m_g1);
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 64'd0, 2'd0, 2'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic        v, f;
    logic [1:0]  c, t;

    reset = 1'b1;
    @(negedge clock);
    idle();
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst count", 64'(count), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_address_0", 64'(out_address_0), 64'd0);
    tick();
    reset = 1'b0;

    // first group visible the cycle after the push
    drive(1'b1, 32'h100, 64'hBBBB0001_AAAA0001, 2'd2, 2'b00, 1'b0); tick();
    idle();
    chk("push out_valid", 64'(out_valid), 64'd3);
    chk("push addr0", 64'(out_address_0), 64'h100);
    chk("push addr1", 64'(out_address_1), 64'h104);
    chk("push instr0", 64'(out_instr_0), 64'hAAAA0001);
    chk("push instr1", 64'(out_instr_1), 64'hBBBB0001);
    chk("push count", 64'(count), 64'd2);
    tick();

    // fill to 7: a further group is refused
    drive(1'b1, 32'h110, 64'h22222222_11111111, 2'd2, 2'b00, 1'b0); tick();
    drive(1'b1, 32'h118, 64'h44444444_33333333, 2'd2, 2'b00, 1'b0); tick();
    drive(1'b1, 32'h120, 64'h00000000_55555555, 2'd1, 2'b00, 1'b0); tick();
    drive(1'b1, 32'h130, 64'h77777777_66666666, 2'd2, 2'b00, 1'b0);
    chk("full in_ready", 64'(in_ready), 64'd0);
    chk("full count", 64'(count), 64'd7);
    tick();
    idle();
    chk("full hold count", 64'(count), 64'd7);
    chk("full hold addr0", 64'(out_address_0), 64'h100);
    tick();

    // drain to 5, then flush with concurrent push and take
    drive(1'b0, 32'd0, 64'd0, 2'd0, 2'b11, 1'b0); tick();
    drive(1'b1, 32'h140, 64'h99999999_88888888, 2'd2, 2'b11, 1'b1);
    chk("preflush count", 64'(count), 64'd5);
    tick();
    idle();
    chk("flush count", 64'(count), 64'd0);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    tick();

    // push 2 + take 1 at count 3
    drive(1'b1, 32'h400, 64'hC0000001_C0000000, 2'd2, 2'b00, 1'b0); tick();
    drive(1'b1, 32'h408, 64'h00000000_C0000002, 2'd1, 2'b00, 1'b0); tick();
    drive(1'b1, 32'h40C, 64'hC0000004_C0000003, 2'd2, 2'b01, 1'b0);
    chk("pp count before", 64'(count), 64'd3);
    tick();
    idle();
    chk("pp count", 64'(count), 64'd4);
    chk("pp addr0", 64'(out_address_0), 64'h404);
    chk("pp instr0", 64'(out_instr_0), 64'hC0000001);
    tick();

    // wrap: rd=1 wr=5 -> push to wr 7, drain, push 2 at index 7
    drive(1'b1, 32'h500, 64'hD0000001_D0000000, 2'd2, 2'b00, 1'b0); tick();
    drive(1'b0, 32'd0, 64'd0, 2'd0, 2'b11, 1'b0); tick();
    drive(1'b0, 32'd0, 64'd0, 2'd0, 2'b11, 1'b0); tick();
    drive(1'b1, 32'h200, 64'hE0000001_E0000000, 2'd2, 2'b00, 1'b0); tick();
    drive(1'b0, 32'd0, 64'd0, 2'd0, 2'b11, 1'b0); tick();
    idle();
    chk("wrap out_valid", 64'(out_valid), 64'd3);
    chk("wrap addr0", 64'(out_address_0), 64'h200);
    chk("wrap addr1", 64'(out_address_1), 64'h204);
    chk("wrap instr0", 64'(out_instr_0), 64'hE0000000);
    chk("wrap instr1", 64'(out_instr_1), 64'hE0000001);
    chk("wrap count", 64'(count), 64'd2);
    tick();
    drive(1'b0, 32'd0, 64'd0, 2'd0, 2'b00, 1'b1); tick();

`ifdef IP_FETCH_QUEUE_BYPASS_EN
    drive(1'b1, 32'h300, 64'hF0000001_F0000000, 2'd2, 2'b11, 1'b0);
    chk("byp out_valid", 64'(out_valid), 64'd3);
    chk("byp addr0", 64'(out_address_0), 64'h300);
    chk("byp addr1", 64'(out_address_1), 64'h304);
    tick();
    idle();
    chk("byp11 count", 64'(count), 64'd0);
    tick();
    drive(1'b1, 32'h300, 64'hF0000001_F0000000, 2'd2, 2'b01, 1'b0);
    chk("byp01 addr0", 64'(out_address_0), 64'h300);
    tick();
    idle();
    chk("byp01 count", 64'(count), 64'd1);
    chk("byp01 addr0 next", 64'(out_address_0), 64'h304);
    tick();
`endif

    // randomized traffic with occasional flush and one mid-run reset
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 9) < 7);
      c = 2'($urandom_range(0, 2));
      if (i < 400) t = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(0, 3)) : 2'b00;
      else         t = 2'($urandom_range(0, 3));
      f = ($urandom_range(0, 29) == 0);
      a = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      if (i == 500) reset = 1'b1;
      drive(v, a, {$urandom(), $urandom()}, c, t, f);
      tick();
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
